// File: rtl/player_motion_ctrl_pkg.sv
// Shared definitions for the player motion controller: key codes, collision-map
// codes, facing direction and FSM state encodings.
package player_motion_ctrl_pkg;

  localparam logic [3:0] KEY_A     = 4'h1;
  localparam logic [3:0] KEY_D     = 4'h2;
  localparam logic [3:0] KEY_W     = 4'h3;
  localparam logic [3:0] KEY_S     = 4'h4;

  localparam logic [3:0] WALL_CODE = 4'h0;
  localparam logic [3:0] DOOR_CODE = 4'h4;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    LEFT  = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PROBE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    HOLD  = 3'd4
  } state_t;

  function automatic logic is_passable(input logic [3:0] pixel, input logic door_open);
    return (pixel != WALL_CODE) && ((pixel != DOOR_CODE) || door_open);
  endfunction

endpackage

// File: rtl/player_motion_ctrl_move_target_calc.sv
// Combinational key decode and one-step target computation with bounds check.
// Arithmetic is one bit wider than the position so the sums never wrap.
module move_target_calc
  import player_motion_ctrl_pkg::*;
#(
  parameter int XPOS_W = 11,
  parameter int YPOS_W = 10,
  parameter int X_MAX  = 2000,
  parameter int Y_MAX  = 767,
  parameter int STEP   = 1
) (
  input  logic [3:0]        i_key,
  input  logic [XPOS_W-1:0] i_xpos,
  input  logic [YPOS_W-1:0] i_ypos,
  output logic [XPOS_W-1:0] o_tgt_x,
  output logic [YPOS_W-1:0] o_tgt_y,
  output dir_t              o_dir,
  output logic              o_valid,
  output logic              o_out_of_range
);

  localparam logic [XPOS_W:0] STEP_X  = (XPOS_W+1)'(STEP);
  localparam logic [YPOS_W:0] STEP_Y  = (YPOS_W+1)'(STEP);
  localparam logic [XPOS_W:0] X_MAX_W = (XPOS_W+1)'(X_MAX);
  localparam logic [YPOS_W:0] Y_MAX_W = (YPOS_W+1)'(Y_MAX);

  logic [XPOS_W:0] w_x_wide, w_x_inc, w_x_dec;
  logic [YPOS_W:0] w_y_wide, w_y_inc, w_y_dec;

  assign w_x_wide = {1'b0, i_xpos};
  assign w_y_wide = {1'b0, i_ypos};
  assign w_x_inc  = w_x_wide + STEP_X;
  assign w_x_dec  = w_x_wide - STEP_X;
  assign w_y_inc  = w_y_wide + STEP_Y;
  assign w_y_dec  = w_y_wide - STEP_Y;

  always_comb begin
    o_tgt_x        = i_xpos;
    o_tgt_y        = i_ypos;
    o_dir          = RIGHT;
    o_valid        = 1'b0;
    o_out_of_range = 1'b0;
    case (i_key)
      KEY_D: begin
        o_dir   = RIGHT;
        o_valid = 1'b1;
        if (w_x_inc > X_MAX_W) o_out_of_range = 1'b1;
        else                   o_tgt_x = w_x_inc[XPOS_W-1:0];
      end
      KEY_A: begin
        o_dir   = LEFT;
        o_valid = 1'b1;
        if (w_x_wide < STEP_X) o_out_of_range = 1'b1;
        else                   o_tgt_x = w_x_dec[XPOS_W-1:0];
      end
      KEY_W: begin
        o_dir   = UP;
        o_valid = 1'b1;
        if (w_y_wide < STEP_Y) o_out_of_range = 1'b1;
        else                   o_tgt_y = w_y_dec[YPOS_W-1:0];
      end
      KEY_S: begin
        o_dir   = DOWN;
        o_valid = 1'b1;
        if (w_y_inc > Y_MAX_W) o_out_of_range = 1'b1;
        else                   o_tgt_y = w_y_inc[YPOS_W-1:0];
      end
      default: begin
        o_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Keyboard-driven 2D player movement with collision-map probing. A registered key
// is decoded in IDLE; the target cell is fetched and the move commits if passable.
module player_motion_ctrl
  import player_motion_ctrl_pkg::*;
#(
  parameter int XPOS_W      = 11,
  parameter int YPOS_W      = 10,
  parameter int X_MAX       = 2000,
  parameter int Y_MAX       = 767,
  parameter int X_INIT      = 0,
  parameter int Y_INIT      = 0,
  parameter int STEP        = 1,
  parameter int TICK_CYCLES = 500000,
  parameter int MAP_SHIFT   = 2,
  parameter int MAP_X_W     = 9,
  parameter int MAP_Y_W     = 7,
  parameter int MAP_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 key,
  input  logic                       door_open,
  input  logic [3:0]                 map_pixel,
  output logic [MAP_Y_W+MAP_X_W-1:0] map_adr,
  output logic                       map_req,
  output logic [XPOS_W-1:0]          player_xpos,
  output logic [YPOS_W-1:0]          player_ypos,
  output dir_t                       direction,
  output logic                       moving,
  output logic                       blocked
);

  localparam int TICK_W = $clog2(TICK_CYCLES + 1);
  localparam int LAT_W  = $clog2(MAP_LATENCY + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'((MAP_LATENCY > 1) ? (MAP_LATENCY - 2) : 0);

  state_t              r_state, w_next_state;
  logic [3:0]          r_key;
  logic [XPOS_W-1:0]   r_tgt_x, w_tgt_x;
  logic [YPOS_W-1:0]   r_tgt_y, w_tgt_y;
  dir_t                r_req_dir, w_dir;
  logic                w_valid, w_oor;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic [MAP_X_W-1:0]  w_col;
  logic [MAP_Y_W-1:0]  w_row;

  move_target_calc #(
    .XPOS_W(XPOS_W), .YPOS_W(YPOS_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .STEP(STEP)
  ) u_target (
    .i_key          (r_key),
    .i_xpos         (player_xpos),
    .i_ypos         (player_ypos),
    .o_tgt_x        (w_tgt_x),
    .o_tgt_y        (w_tgt_y),
    .o_dir          (w_dir),
    .o_valid        (w_valid),
    .o_out_of_range (w_oor)
  );

  assign w_col = MAP_X_W'(w_tgt_x >> MAP_SHIFT);
  assign w_row = MAP_Y_W'(w_tgt_y >> MAP_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_next_state = w_oor ? HOLD : PROBE;
               else         w_next_state = IDLE;
      PROBE:   w_next_state = (MAP_LATENCY == 1) ? CHECK : WAIT;
      WAIT:    if (r_lat_cnt == LAT_LAST) w_next_state = CHECK;
               else                       w_next_state = WAIT;
      CHECK:   w_next_state = HOLD;
      HOLD:    if (r_tick_cnt == TICK_LAST) w_next_state = IDLE;
               else                         w_next_state = HOLD;
      default: w_next_state = IDLE;
    endcase
  end

  // Strobes default low each cycle; map_req rises together with entry into PROBE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key       <= 4'h0;
      r_tgt_x     <= XPOS_W'(X_INIT);
      r_tgt_y     <= YPOS_W'(Y_INIT);
      r_req_dir   <= RIGHT;
      r_tick_cnt  <= '0;
      r_lat_cnt   <= '0;
      map_adr     <= '0;
      map_req     <= 1'b0;
      player_xpos <= XPOS_W'(X_INIT);
      player_ypos <= YPOS_W'(Y_INIT);
      direction   <= RIGHT;
      moving      <= 1'b0;
      blocked     <= 1'b0;
    end else begin
      r_key   <= key;
      map_req <= 1'b0;
      moving  <= 1'b0;
      blocked <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_tgt_x   <= w_tgt_x;
            r_tgt_y   <= w_tgt_y;
            r_req_dir <= w_dir;
            if (w_oor) begin
              direction <= w_dir;
              blocked   <= 1'b1;
            end else begin
              map_req <= 1'b1;
              map_adr <= {w_row, w_col};
            end
          end
        end
        PROBE: r_lat_cnt <= '0;
        WAIT:  r_lat_cnt <= r_lat_cnt + 1'b1;
        CHECK: begin
          direction <= r_req_dir;
          if (is_passable(map_pixel, door_open)) begin
            player_xpos <= r_tgt_x;
            player_ypos <= r_tgt_y;
            moving      <= 1'b1;
          end else begin
            blocked <= 1'b1;
          end
        end
        HOLD: begin
          if (r_tick_cnt == TICK_LAST) r_tick_cnt <= '0;
          else                         r_tick_cnt <= r_tick_cnt + 1'b1;
        end
        default: r_lat_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed plus randomized bench for player_motion_ctrl over three instances:
// floor start (10,20), corner (2000,0), and origin with 3-cycle map latency.
module tb_player_motion_ctrl;
  import player_motion_ctrl_pkg::*;

  localparam int NI = 3;
  localparam int LATS  [NI] = '{1, 1, 3};
  localparam int XINIT [NI] = '{10, 2000, 0};
  localparam int YINIT [NI] = '{20, 0, 0};
  localparam int TICK  = 4;

  logic       clk = 1'b0;
  logic       rstn_s [NI];
  logic [3:0] key_s  [NI];
  logic       door_s [NI];
  logic [3:0] pix_s  [NI];
  wire [15:0] adr_w  [NI];
  wire        req_w  [NI];
  wire [10:0] x_w    [NI];
  wire [9:0]  y_w    [NI];
  wire [1:0]  dir_w  [NI];
  wire        mov_w  [NI];
  wire        blk_w  [NI];

  int n_assert = 0;
  int n_fail   = 0;
  int xm [NI];
  int ym [NI];
  int dm [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    player_motion_ctrl #(
      .TICK_CYCLES(TICK), .MAP_LATENCY(LATS[g]), .X_INIT(XINIT[g]), .Y_INIT(YINIT[g])
    ) dut (
      .clk(clk), .rst_n(rstn_s[g]), .key(key_s[g]), .door_open(door_s[g]),
      .map_pixel(pix_s[g]), .map_adr(adr_w[g]), .map_req(req_w[g]),
      .player_xpos(x_w[g]), .player_ypos(y_w[g]), .direction(dir_w[g]),
      .moving(mov_w[g]), .blocked(blk_w[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_pos(input int i, input string tag);
    chk({tag, ".x"}, 32'(x_w[i]), xm[i]);
    chk({tag, ".y"}, 32'(y_w[i]), ym[i]);
    chk({tag, ".dir"}, 32'(dir_w[i]), dm[i]);
  endtask

  // One key press (one cycle wide) on instance i, with the map answering 'pix'
  // exactly at the check cycle and 'early' in the cycles before it.
  task automatic op(input int i, input logic [3:0] k, input logic [3:0] pix,
                    input logic door, input logic [3:0] early, input string tag);
    int  tx, ty, d, lat;
    bit  valid, oob, pass;
    lat   = LATS[i];
    tx    = xm[i];
    ty    = ym[i];
    d     = 0;
    valid = 1'b1;
    if (k == KEY_D)      begin tx = tx + 1; d = 0; end
    else if (k == KEY_A) begin tx = tx - 1; d = 1; end
    else if (k == KEY_W) begin ty = ty - 1; d = 2; end
    else if (k == KEY_S) begin ty = ty + 1; d = 3; end
    else valid = 1'b0;
    oob = (tx < 0) || (tx > 2000) || (ty < 0) || (ty > 767);

    key_s[i] = k;
    tick();
    key_s[i] = 4'h0;
    tick();
    if (!valid) begin
      chk({tag, ".req_none"}, 32'(req_w[i]), 0);
      chk({tag, ".blk_none"}, 32'(blk_w[i]), 0);
      repeat (3) tick();
      chk_pos(i, {tag, ".idle"});
      return;
    end
    if (oob) begin
      dm[i] = d;
      chk({tag, ".req_oob"}, 32'(req_w[i]), 0);
      chk({tag, ".blk_oob"}, 32'(blk_w[i]), 1);
      chk_pos(i, {tag, ".oob"});
      tick();
      chk({tag, ".blk_once"}, 32'(blk_w[i]), 0);
      repeat (6) tick();
      return;
    end
    chk({tag, ".req"}, 32'(req_w[i]), 1);
    chk({tag, ".adr"}, 32'(adr_w[i]), ((ty / 4) % 128) * 512 + (tx / 4) % 512);
    for (int c = 1; c <= lat; c++) begin
      tick();
      if (c == 1) chk({tag, ".req_drop"}, 32'(req_w[i]), 0);
      pix_s[i]  = (c == lat) ? pix : early;
      door_s[i] = (c == lat) ? door : ~door;
    end
    tick();
    pix_s[i]  = 4'($urandom_range(0, 15));
    door_s[i] = 1'($urandom_range(0, 1));
    pass  = (pix != 4'h0) && ((pix != 4'h4) || door);
    dm[i] = d;
    if (pass) begin
      xm[i] = tx;
      ym[i] = ty;
    end
    chk({tag, ".moving"}, 32'(mov_w[i]), 32'(pass));
    chk({tag, ".blocked"}, 32'(blk_w[i]), 32'(!pass));
    chk({tag, ".adr_hold"}, 32'(adr_w[i]), ((ty / 4) % 128) * 512 + (tx / 4) % 512);
    chk_pos(i, tag);
    tick();
    chk({tag, ".mov_once"}, 32'(mov_w[i]), 0);
    chk({tag, ".blk_once"}, 32'(blk_w[i]), 0);
    repeat (6) tick();
  endtask

  initial begin
    int  cnt;
    bit  found;
    logic [3:0] k, p;
    for (int i = 0; i < NI; i++) begin
      rstn_s[i] = 1'b0;
      key_s[i]  = 4'h0;
      door_s[i] = 1'b0;
      pix_s[i]  = 4'h0;
      xm[i]     = XINIT[i];
      ym[i]     = YINIT[i];
      dm[i]     = 0;
    end
    repeat (2) tick();
    for (int i = 0; i < NI; i++) rstn_s[i] = 1'b1;
    for (int i = 0; i < NI; i++) begin
      chk_pos(i, "reset");
      chk("reset.req", 32'(req_w[i]), 0);
      chk("reset.mov", 32'(mov_w[i]), 0);
      chk("reset.blk", 32'(blk_w[i]), 0);
    end
    tick();

    op(0, KEY_D, 4'h7, 1'b0, 4'h0, "floor_right");
    op(0, KEY_D, 4'h0, 1'b1, 4'h7, "wall");
    op(0, KEY_D, 4'h4, 1'b0, 4'h7, "door_closed");
    op(0, KEY_D, 4'h4, 1'b1, 4'h0, "door_open");
    op(0, 4'h9,  4'h7, 1'b0, 4'h7, "bad_key");

    // Held key: map_req repeats every TICK+3 cycles at latency 1.
    pix_s[0] = 4'h7;
    key_s[0] = KEY_D;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      tick();
      found = req_w[0];
    end
    chk("held.first_req", 32'(found), 1);
    found = 1'b0;
    cnt   = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      tick();
      cnt++;
      found = req_w[0];
    end
    chk("held.second_req", 32'(found), 1);
    chk("held.period", cnt, TICK + 3);
    key_s[0] = 4'h0;
    xm[0] = xm[0] + 2;
    repeat (12) tick();
    chk_pos(0, "held");

    op(1, KEY_D, 4'h7, 1'b0, 4'h7, "xmax_right");
    op(1, KEY_W, 4'h7, 1'b0, 4'h7, "ymin_up");
    op(1, KEY_S, 4'h7, 1'b0, 4'h0, "corner_down");
    op(1, KEY_A, 4'h7, 1'b0, 4'h0, "corner_left");

    op(2, KEY_A, 4'h7, 1'b0, 4'h7, "xmin_left");
    op(2, KEY_W, 4'h7, 1'b0, 4'h7, "ymin_up_lat3");
    op(2, KEY_D, 4'h7, 1'b0, 4'h0, "lat3_late_floor");
    op(2, KEY_S, 4'h0, 1'b1, 4'h7, "lat3_late_wall");

    // Reset during HOLD: position returns to init and a key is taken at once.
    key_s[2] = KEY_D;
    tick();
    key_s[2] = 4'h0;
    tick();
    pix_s[2] = 4'h7;
    repeat (4) tick();
    chk("hold_rst.pre_x", 32'(x_w[2]), xm[2] + 1);
    tick();
    rstn_s[2] = 1'b0;
    tick();
    rstn_s[2] = 1'b1;
    xm[2] = 0;
    ym[2] = 0;
    dm[2] = 0;
    chk_pos(2, "hold_rst");
    op(2, KEY_S, 4'h7, 1'b0, 4'h0, "after_rst");

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 5))
        0:       k = KEY_A;
        1:       k = KEY_D;
        2:       k = KEY_W;
        3:       k = KEY_S;
        4:       k = 4'($urandom_range(5, 15));
        default: k = 4'($urandom_range(1, 4));
      endcase
      case ($urandom_range(0, 3))
        0:       p = 4'h0;
        1:       p = 4'h4;
        2:       p = 4'h7;
        default: p = 4'($urandom_range(0, 15));
      endcase
      op(0, k, p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
